comms_debug_trace_capture: RTL and testbench

//  On-chip logic-analyser stage for CommsFPGA debug signals. Continuously samples a 16-bit

---
 rtl/comms_debug_trace_capture_if.sv | 20 ++
 rtl/comms_debug_trace_capture.sv | 157 +++++++++++++++
 tb/tb_comms_debug_trace_capture.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comms_debug_trace_capture_if.sv
// APB3 slave bundle for the CommsFPGA debug trace capture block (8-bit data, 8-bit byte address).
interface comms_debug_trace_capture_if;
    logic       apb3_sel;
    logic       apb3_enable;
    logic       apb3_write;
    logic [7:0] apb3_addr;
    logic [7:0] apb3_wdata;
    logic [7:0] apb3_rdata;
    logic       apb3_ready;

    modport master (
        output apb3_sel, apb3_enable, apb3_write, apb3_addr, apb3_wdata,
        input  apb3_rdata, apb3_ready
    );

    modport slave (
        input  apb3_sel, apb3_enable, apb3_write, apb3_addr, apb3_wdata,
        output apb3_rdata, apb3_ready
    );
endinterface

// File: rtl/comms_debug_trace_capture.sv
// On-chip logic analyser: circular capture of a 16-bit probe bus, frozen POST samples after a
// masked trigger, read back over APB3. Optional macro TRACE_EDGE_TRIG_EN selects an edge trigger.
module comms_debug_trace_capture #(
    parameter int ADDR_W  = 8,
    parameter int PROBE_W = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [PROBE_W-1:0]         probe,
    comms_debug_trace_capture_if.slave apb,
    output logic                       trace_done
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_TRIG  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] A_CTRL    = 8'h00;
    localparam logic [7:0] A_STATUS  = 8'h01;
    localparam logic [7:0] A_MASK    = 8'h02;
    localparam logic [7:0] A_VALUE   = 8'h03;
    localparam logic [7:0] A_POST    = 8'h04;
    localparam logic [7:0] A_TRIGPTR = 8'h05;
    localparam logic [7:0] A_RDPTR   = 8'h06;
    localparam logic [7:0] A_RDLO    = 8'h07;
    localparam logic [7:0] A_RDHI    = 8'h08;

    logic [1:0]         state;
    logic [7:0]         mask_r;
    logic [7:0]         value_r;
    logic [7:0]         post_r;
    logic [7:0]         post_cnt;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  trig_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic               wrapped;

    logic [PROBE_W-1:0] mem [DEPTH];
    logic [PROBE_W-1:0] rd_data_p1;

    logic wr_acc;
    logic rd_acc;
    logic arm;
    logic abort;
    logic wr_en;
    logic match_raw;
    logic fire;
    logic [7:0] rdata_c;

    assign wr_acc = apb.apb3_sel & apb.apb3_enable & apb.apb3_write;
    assign rd_acc = apb.apb3_sel & apb.apb3_enable & ~apb.apb3_write;

    // ABORT dominates ARM when both control bits are written together
    assign abort = wr_acc && (apb.apb3_addr == A_CTRL) && apb.apb3_wdata[1];
    assign arm   = wr_acc && (apb.apb3_addr == A_CTRL) && apb.apb3_wdata[0] && !apb.apb3_wdata[1];

    assign match_raw = ((probe[7:0] ^ value_r) & mask_r) == 8'h00;
    assign wr_en     = (state == ST_ARMED) || (state == ST_TRIG);

`ifdef TRACE_EDGE_TRIG_EN
    logic match_q;

    // match_q tracks the condition continuously, so a level already present when ARM lands
    // counts as old and only a fresh false->true transition fires
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_raw;
        end
    end

    assign fire = match_raw & ~match_q;
`else
    assign fire = match_raw;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            mask_r   <= 8'h00;
            value_r  <= 8'h00;
            post_r   <= 8'h80;
            post_cnt <= 8'h00;
            wr_ptr   <= '0;
            trig_ptr <= '0;
            rd_ptr   <= '0;
            wrapped  <= 1'b0;
        end else begin
            if (wr_acc && apb.apb3_addr == A_MASK)  mask_r  <= apb.apb3_wdata;
            if (wr_acc && apb.apb3_addr == A_VALUE) value_r <= apb.apb3_wdata;
            if (wr_acc && apb.apb3_addr == A_POST)  post_r  <= apb.apb3_wdata;

            if (wr_acc && apb.apb3_addr == A_RDPTR) begin
                rd_ptr <= ADDR_W'(apb.apb3_wdata);
            end else if (rd_acc && apb.apb3_addr == A_RDHI) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end

            if (abort) begin
                state <= ST_IDLE;
            end else if (arm) begin
                state    <= ST_ARMED;
                wr_ptr   <= '0;
                wrapped  <= 1'b0;
                post_cnt <= post_r;
            end else begin
                case (state)
                    ST_ARMED: begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                        if (wr_ptr == {ADDR_W{1'b1}}) wrapped <= 1'b1;
                        if (fire) begin
                            trig_ptr <= wr_ptr;
                            state    <= (post_cnt == 8'h00) ? ST_DONE : ST_TRIG;
                        end
                    end
                    ST_TRIG: begin
                        wr_ptr   <= wr_ptr + ADDR_W'(1);
                        if (wr_ptr == {ADDR_W{1'b1}}) wrapped <= 1'b1;
                        post_cnt <= post_cnt - 8'h01;
                        if (post_cnt == 8'h01) state <= ST_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---- trace RAM write and registered readback (p1) ----
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= probe;
        rd_data_p1 <= mem[rd_ptr];
    end

    always_comb begin
        rdata_c = 8'h00;
        if (rd_acc) begin
            case (apb.apb3_addr)
                A_STATUS:  rdata_c = {5'd0, wrapped, state};
                A_MASK:    rdata_c = mask_r;
                A_VALUE:   rdata_c = value_r;
                A_POST:    rdata_c = post_r;
                A_TRIGPTR: rdata_c = 8'(trig_ptr);
                A_RDPTR:   rdata_c = 8'(rd_ptr);
                A_RDLO:    rdata_c = rd_data_p1[7:0];
                A_RDHI:    rdata_c = rd_data_p1[15:8];
                default:   rdata_c = 8'h00;
            endcase
        end
    end

    assign apb.apb3_rdata = rdata_c;
    assign apb.apb3_ready = 1'b1;
    assign trace_done     = (state == ST_DONE);
endmodule

// File: tb/tb_comms_debug_trace_capture.sv
// Scoreboard bench for comms_debug_trace_capture; honours TRACE_EDGE_TRIG_EN when defined.
module tb_comms_debug_trace_capture;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] probe;
    logic        trace_done;

    comms_debug_trace_capture_if apb();

    comms_debug_trace_capture dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .probe      (probe),
        .apb        (apb),
        .trace_done (trace_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] val;
    } rd_exp_t;

    rd_exp_t     sb[$];
    int          checks = 0;
    int          failures = 0;
    logic        ramp_en = 1'b0;
    logic [15:0] ramp_step = 16'h0001;

    task automatic tick();
        @(posedge clk);
        #2;
        if (ramp_en) probe = probe + ramp_step;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        apb.apb3_sel = 1'b1; apb.apb3_enable = 1'b0; apb.apb3_write = 1'b1;
        apb.apb3_addr = a; apb.apb3_wdata = d;
        tick();
        apb.apb3_enable = 1'b1;
        tick();
        apb.apb3_sel = 1'b0; apb.apb3_enable = 1'b0; apb.apb3_write = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
        apb.apb3_sel = 1'b1; apb.apb3_enable = 1'b0; apb.apb3_write = 1'b0;
        apb.apb3_addr = a;
        tick();
        apb.apb3_enable = 1'b1;
        #1 d = apb.apb3_rdata;
        tick();
        apb.apb3_sel = 1'b0; apb.apb3_enable = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (trace_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        rd_exp_t     e;
        logic [7:0]  d;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            apb_read(e.addr, d);
            checks++;
            if (d !== e.val) begin
                failures++;
                $display("FAIL %s rd[%02h]: got %02h expected %02h", tag, e.addr, d, e.val);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_regs [9];
        exp_regs = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        checks++;
        if (trace_done !== 1'b0) begin
            failures++;
            $display("FAIL reset trace_done: got %b expected 0", trace_done);
        end
        checks++;
        if (apb.apb3_ready !== 1'b1 || apb.apb3_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset ready/rdata: got %b/%02h expected 1/00", apb.apb3_ready, apb.apb3_rdata);
        end
        for (int i = 0; i < 9; i++) sb.push_back('{addr: 8'(i), val: exp_regs[i]});
        sb.push_back('{addr: 8'h09, val: 8'h00});
        sb.push_back('{addr: 8'h40, val: 8'h00});
        apb_write(8'h20, 8'hAA);
        sb.push_back('{addr: 8'h20, val: 8'h00});
        drain("reset");
    endtask

    task automatic test_capture();
        bit ok;
        apb_write(8'h02, 8'hFF);
        apb_write(8'h03, 8'h5A);
        apb_write(8'h04, 8'h04);
        sb.push_back('{addr: 8'h02, val: 8'hFF});
        sb.push_back('{addr: 8'h03, val: 8'h5A});
        sb.push_back('{addr: 8'h04, val: 8'h04});
        drain("capture_cfg");
        apb_write(8'h00, 8'h01);
        probe = 16'h0000; ramp_step = 16'h0001; ramp_en = 1'b1;
        wait_done(400, ok);
        ramp_en = 1'b0;
        checks++;
        if (!ok || probe !== 16'h005F) begin
            failures++;
            $display("FAIL capture done_timing: done=%b probe=%04h expected done=1 probe=005f", ok, probe);
        end
        sb.push_back('{addr: 8'h01, val: 8'h03});
        sb.push_back('{addr: 8'h05, val: 8'h5A});
        drain("capture_stat");
        apb_write(8'h06, 8'h5A);
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{addr: 8'h07, val: 8'(8'h5A + k)});
            sb.push_back('{addr: 8'h08, val: 8'h00});
        end
        sb.push_back('{addr: 8'h06, val: 8'h5F});
        drain("capture_rd");
    endtask

    task automatic test_post_zero();
        apb_write(8'h02, 8'h00);
        apb_write(8'h04, 8'h00);
        apb_write(8'h00, 8'h01);
        checks++;
        if (trace_done !== 1'b0) begin
            failures++;
            $display("FAIL post0 armed: got trace_done=%b expected 0", trace_done);
        end
        tick();
        checks++;
        if (trace_done !== 1'b1) begin
            failures++;
            $display("FAIL post0 done: got trace_done=%b expected 1", trace_done);
        end
        sb.push_back('{addr: 8'h01, val: 8'h03});
        sb.push_back('{addr: 8'h05, val: 8'h00});
        drain("post0");
    endtask

    task automatic test_wrap();
        bit ok;
        apb_write(8'h02, 8'hFF);
        apb_write(8'h03, 8'hC3);
        apb_write(8'h04, 8'h80);
        apb_write(8'h00, 8'h01);
        probe = 16'h0011; ramp_step = 16'h0100; ramp_en = 1'b1;
        repeat (300) tick();
        probe[7:0] = 8'hC3;
        wait_done(200, ok);
        ramp_en = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wrap done: got 0 expected 1");
        end
        sb.push_back('{addr: 8'h01, val: 8'h07});
        sb.push_back('{addr: 8'h05, val: 8'h2C});
        drain("wrap_stat");
        apb_write(8'h06, 8'h2C);
        sb.push_back('{addr: 8'h07, val: 8'hC3});
        sb.push_back('{addr: 8'h08, val: 8'h2C});
        drain("wrap_trig");
        apb_write(8'h06, 8'hFF);
        sb.push_back('{addr: 8'h08, val: 8'hFF});
        sb.push_back('{addr: 8'h06, val: 8'h00});
        sb.push_back('{addr: 8'h07, val: 8'h11});
        drain("wrap_ptr");
    endtask

    task automatic test_abort();
        bit ok;
        apb_write(8'h03, 8'h20);
        apb_write(8'h04, 8'h80);
        apb_write(8'h00, 8'h01);
        probe = 16'h0000; ramp_step = 16'h0001; ramp_en = 1'b1;
        repeat (48) tick();
        sb.push_back('{addr: 8'h01, val: 8'h02});
        drain("abort_trig");
        apb_write(8'h00, 8'h03);
        checks++;
        if (trace_done !== 1'b0) begin
            failures++;
            $display("FAIL abort trace_done: got %b expected 0", trace_done);
        end
        sb.push_back('{addr: 8'h01, val: 8'h00});
        drain("abort_idle");
        apb_write(8'h03, 8'h40);
        apb_write(8'h04, 8'h02);
        apb_write(8'h00, 8'h01);
        probe = 16'h0000;
        wait_done(200, ok);
        ramp_en = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rearm done: got 0 expected 1");
        end
        sb.push_back('{addr: 8'h05, val: 8'h40});
        drain("rearm_stat");
        apb_write(8'h06, 8'h40);
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{addr: 8'h07, val: 8'(8'h40 + k)});
            sb.push_back('{addr: 8'h08, val: 8'h00});
        end
        drain("rearm_rd");
    endtask

    task automatic test_edge_trig();
        apb_write(8'h02, 8'hFF);
        apb_write(8'h03, 8'h77);
        apb_write(8'h04, 8'h00);
        probe = 16'h0077;
        apb_write(8'h00, 8'h01);
`ifdef TRACE_EDGE_TRIG_EN
        repeat (10) tick();
        checks++;
        if (trace_done !== 1'b0) begin
            failures++;
            $display("FAIL edge held_level: got trace_done=%b expected 0", trace_done);
        end
        probe = 16'h0000;
        repeat (3) tick();
        probe = 16'h0077;
        tick();
        checks++;
        if (trace_done !== 1'b1) begin
            failures++;
            $display("FAIL edge rising: got trace_done=%b expected 1", trace_done);
        end
        sb.push_back('{addr: 8'h05, val: 8'h0D});
`else
        tick();
        checks++;
        if (trace_done !== 1'b1) begin
            failures++;
            $display("FAIL level first_cycle: got trace_done=%b expected 1", trace_done);
        end
        sb.push_back('{addr: 8'h05, val: 8'h00});
`endif
        drain("edge");
    endtask

    task automatic test_async_reset();
        apb_write(8'h04, 8'h10);
        apb_write(8'h02, 8'h00);
        apb_write(8'h00, 8'h01);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (trace_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset trace_done: got %b expected 0", trace_done);
        end
        tick();
        reset_n = 1'b1;
        sb.push_back('{addr: 8'h01, val: 8'h00});
        sb.push_back('{addr: 8'h04, val: 8'h80});
        sb.push_back('{addr: 8'h02, val: 8'h00});
        drain("async_reset");
    endtask

    initial begin
        reset_n = 1'b0;
        probe = 16'h0000;
        apb.apb3_sel = 1'b0; apb.apb3_enable = 1'b0; apb.apb3_write = 1'b0;
        apb.apb3_addr = 8'h00; apb.apb3_wdata = 8'h00;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        test_reset();
        test_capture();
        test_post_zero();
        test_wrap();
        test_abort();
        test_edge_trig();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
